// File: rtl/mips_multicycle_control.sv
// Control FSM for the shared multi-cycle MIPS datapath: sequences fetch/decode/execute/
// memory/write-back, stalls on mem_ready, counts retirements and traps unsupported opcodes.
module mips_multicycle_control (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_ctrl,
    output logic [1:0]  pc_src,
    output logic        ext_zero,
    output logic [3:0]  state,
    output logic        retired,
    output logic [31:0] inst_count,
    output logic        illegal
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        RTYPE_EX = 4'd6,
        ALU_WB   = 4'd7,
        BEQ_EX   = 4'd8,
        IMM_EX   = 4'd9,
        J_EX     = 4'd10,
        TRAP     = 4'd11
    } state_t;

    typedef enum logic [2:0] {
        CLS_RTYPE,
        CLS_LW,
        CLS_SW,
        CLS_BEQ,
        CLS_ADDI,
        CLS_ANDI,
        CLS_ORI,
        CLS_J
    } op_class_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t    state_q, state_d;
    op_class_t op_class_q, dec_class;
    logic      dec_legal;
    logic [2:0] rtype_ctrl;

    logic pc_write, branch;
    logic mem_read_raw, mem_write_raw, ir_write_raw, reg_write_raw, retired_raw;

    // Instruction decode: classify the opcode and reject anything outside the supported set.
    always_comb begin
        dec_class = CLS_RTYPE;
        dec_legal = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: dec_legal = 1'b1;
                    default:                               dec_legal = 1'b0;
                endcase
            end
            OP_LW:   dec_class = CLS_LW;
            OP_SW:   dec_class = CLS_SW;
            OP_BEQ:  dec_class = CLS_BEQ;
            OP_ADDI: dec_class = CLS_ADDI;
            OP_ANDI: dec_class = CLS_ANDI;
            OP_ORI:  dec_class = CLS_ORI;
            OP_J:    dec_class = CLS_J;
            default: dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        case (funct)
            FN_SUB:  rtype_ctrl = ALU_SUB;
            FN_AND:  rtype_ctrl = ALU_AND;
            FN_OR:   rtype_ctrl = ALU_OR;
            FN_SLT:  rtype_ctrl = ALU_SLT;
            default: rtype_ctrl = ALU_ADD;
        endcase
    end

    // Next-state and raw control outputs; strobes are gated by reset further down.
    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        branch        = 1'b0;
        iord          = 1'b0;
        mem_read_raw  = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        retired_raw   = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_ctrl      = ALU_ADD;
        pc_src        = 2'b00;
        ext_zero      = 1'b0;

        case (state_q)
            FETCH: begin
                mem_read_raw = 1'b1;
                alu_src_b    = 2'b01;
                if (mem_ready) begin
                    ir_write_raw = 1'b1;
                    pc_write     = 1'b1;
                    state_d      = DECODE;
                end
            end
            DECODE: begin
                alu_src_b = 2'b11;
                if (!dec_legal) begin
                    state_d = TRAP;
                end else begin
                    case (dec_class)
                        CLS_LW, CLS_SW:               state_d = MEMADR;
                        CLS_RTYPE:                    state_d = RTYPE_EX;
                        CLS_BEQ:                      state_d = BEQ_EX;
                        CLS_ADDI, CLS_ANDI, CLS_ORI:  state_d = IMM_EX;
                        default:                      state_d = J_EX;
                    endcase
                end
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (op_class_q == CLS_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                mem_read_raw = 1'b1;
                iord         = 1'b1;
                if (mem_ready) state_d = MEMWB;
            end
            MEMWB: begin
                reg_write_raw = 1'b1;
                mem_to_reg    = 1'b1;
                retired_raw   = 1'b1;
                state_d       = FETCH;
            end
            MEMWR: begin
                mem_write_raw = 1'b1;
                iord          = 1'b1;
                if (mem_ready) begin
                    retired_raw = 1'b1;
                    state_d     = FETCH;
                end
            end
            RTYPE_EX: begin
                alu_src_a = 1'b1;
                alu_ctrl  = rtype_ctrl;
                state_d   = ALU_WB;
            end
            ALU_WB: begin
                reg_write_raw = 1'b1;
                reg_dst       = (op_class_q == CLS_RTYPE);
                retired_raw   = 1'b1;
                state_d       = FETCH;
            end
            BEQ_EX: begin
                alu_src_a   = 1'b1;
                alu_ctrl    = ALU_SUB;
                branch      = 1'b1;
                pc_src      = 2'b01;
                retired_raw = 1'b1;
                state_d     = FETCH;
            end
            IMM_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (op_class_q)
                    CLS_ANDI: begin
                        alu_ctrl = ALU_AND;
                        ext_zero = 1'b1;
                    end
                    CLS_ORI: begin
                        alu_ctrl = ALU_OR;
                        ext_zero = 1'b1;
                    end
                    default: alu_ctrl = ALU_ADD;
                endcase
                state_d = ALU_WB;
            end
            J_EX: begin
                pc_write    = 1'b1;
                pc_src      = 2'b10;
                retired_raw = 1'b1;
                state_d     = FETCH;
            end
            TRAP:    state_d = TRAP;
            default: state_d = FETCH;
        endcase
    end

    // The opcode class is captured while leaving DECODE so later states need not rely on the IR.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= FETCH;
            op_class_q <= CLS_RTYPE;
            inst_count <= 32'd0;
            illegal    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE) op_class_q <= dec_class;
            if (retired_raw) inst_count <= inst_count + 32'd1;
            if (state_d == TRAP) illegal <= 1'b1;
        end
    end

    assign pc_en     = reset & (pc_write | (branch & zero));
    assign mem_read  = reset & mem_read_raw;
    assign mem_write = reset & mem_write_raw;
    assign ir_write  = reset & ir_write_raw;
    assign reg_write = reset & reg_write_raw;
    assign retired   = reset & retired_raw;
    assign state     = state_q;

endmodule
